// File: rtl/apple_bus_arbiter_if.sv
// Shared-RAM bus between the Apple IIe arbiter, its three requesters and the RAM.
// The master modport is the arbiter side; the slave modport is the requester/RAM side.
interface apple_bus_arbiter_if;
    logic        phi0;

    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;

    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ce;

    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        dma_grant;
    logic [7:0]  dma_rdata;
    logic        dma_done;

    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport master (
        output phi0, vid_data, vid_valid, cpu_rdata, cpu_ce,
               dma_grant, dma_rdata, dma_done, ram_addr, ram_we, ram_wdata,
        input  vid_req, vid_addr, cpu_addr, cpu_rw, cpu_wdata,
               dma_req, dma_addr, dma_we, dma_wdata, ram_rdata
    );

    modport slave (
        input  phi0, vid_data, vid_valid, cpu_rdata, cpu_ce,
               dma_grant, dma_rdata, dma_done, ram_addr, ram_we, ram_wdata,
        output vid_req, vid_addr, cpu_addr, cpu_rw, cpu_wdata,
               dma_req, dma_addr, dma_we, dma_wdata, ram_rdata
    );
endinterface

// File: rtl/apple_bus_arbiter.sv
// Time-division arbiter for Apple IIe main RAM: video owns the phi1 half of each bus
// cycle, the CPU or a burst-limited DMA requester owns the phi0 half.
module apple_bus_arbiter #(
    parameter int HALF_LEN  = 25,
    parameter int DMA_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    apple_bus_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(2 * HALF_LEN);
    localparam int BST_W = $clog2(DMA_BURST + 1);

    localparam logic [CNT_W-1:0] CNT_VID_CAP  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_PRE_SEL  = CNT_W'(HALF_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SEL      = CNT_W'(HALF_LEN);
    localparam logic [CNT_W-1:0] CNT_SLOT_CAP = CNT_W'(HALF_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_PRE_END  = CNT_W'(2 * HALF_LEN - 2);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(2 * HALF_LEN - 1);
    localparam logic [BST_W-1:0] BURST_MAX    = BST_W'(DMA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_CPU_SLOT,
        ST_DMA_SLOT
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BST_W-1:0]   burst_q, burst_d;
    logic               dma_win;

    logic               phi0_q;
    logic               vid_pend_q;
    logic               slot_rd_q;
    logic [15:0]        ram_addr_q;
    logic               ram_we_q;
    logic [7:0]         ram_wdata_q;
    logic [7:0]         vid_data_q;
    logic               vid_valid_q;
    logic [7:0]         cpu_rdata_q;
    logic               cpu_ce_q;
    logic [7:0]         dma_rdata_q;
    logic               dma_grant_q;
    logic               dma_done_q;

    always_comb begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        dma_win = bus.dma_req && (burst_q < BURST_MAX);
        burst_d = burst_q;
        if (cnt_q == CNT_SEL) begin
            burst_d = dma_win ? burst_q + BST_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and wins over everything, so a write strobe that
        // would have been raised on the reset edge never reaches the RAM.
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            burst_q     <= '0;
            phi0_q      <= 1'b0;
            vid_pend_q  <= 1'b0;
            slot_rd_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ce_q    <= 1'b0;
            dma_rdata_q <= '0;
            dma_grant_q <= 1'b0;
            dma_done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            phi0_q  <= (cnt_d >= CNT_SEL);

            // NOTE: one-clock strobes default low here; a later non-blocking assignment
            // in this block overrides the default for the clock it applies to.
            ram_we_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_ce_q    <= 1'b0;
            dma_done_q  <= 1'b0;

            if (cnt_q == '0 && bus.vid_req) begin
                ram_addr_q <= bus.vid_addr;
                vid_pend_q <= 1'b1;
            end
            if (cnt_q == CNT_VID_CAP && vid_pend_q) begin
                vid_data_q  <= bus.ram_rdata;
                vid_valid_q <= 1'b1;
                vid_pend_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == CNT_PRE_SEL) state_q <= ST_SEL;
                end
                ST_SEL: begin
                    state_q     <= dma_win ? ST_DMA_SLOT : ST_CPU_SLOT;
                    dma_grant_q <= dma_win;
                    if (dma_win) begin
                        ram_addr_q  <= bus.dma_addr;
                        ram_wdata_q <= bus.dma_wdata;
                        ram_we_q    <= bus.dma_we;
                        slot_rd_q   <= !bus.dma_we;
                    end else begin
                        ram_addr_q  <= bus.cpu_addr;
                        ram_wdata_q <= bus.cpu_wdata;
                        ram_we_q    <= !bus.cpu_rw;
                        slot_rd_q   <= bus.cpu_rw;
                    end
                end
                default: begin
                    // Owner is fixed for the rest of the slot, even if dma_req drops early.
                    if (cnt_q == CNT_SLOT_CAP && slot_rd_q) begin
                        if (state_q == ST_DMA_SLOT) dma_rdata_q <= bus.ram_rdata;
                        else                        cpu_rdata_q <= bus.ram_rdata;
                    end
                    if (cnt_q == CNT_PRE_END) begin
                        cpu_ce_q   <= (state_q == ST_CPU_SLOT);
                        dma_done_q <= (state_q == ST_DMA_SLOT);
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_IDLE;
                        dma_grant_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.phi0      = phi0_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.dma_grant = dma_grant_q;
    assign bus.dma_done  = dma_done_q;
endmodule

// File: tb/tb_apple_bus_arbiter.sv
// Self-checking bench: directed bus-cycle scenarios plus random traffic, every clock
// compared against a per-bus-cycle reference model of the arbitration rules.
module tb_apple_bus_arbiter;
    localparam int HALF_LEN  = 25;
    localparam int DMA_BURST = 4;
    localparam int PERIOD    = 2 * HALF_LEN;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    apple_bus_arbiter_if bus ();

    apple_bus_arbiter #(.HALF_LEN(HALF_LEN), .DMA_BURST(DMA_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Synchronous-read RAM seen by the DUT: data one clock after the address.
    logic [7:0] mem [0:65535] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Reference model state.
    logic [7:0] ref_mem [0:65535] = '{default: 8'h00};
    int         burst_run;
    logic [7:0] exp_vid_data, exp_cpu_rdata, exp_dma_rdata;

    typedef struct packed {
        logic        vreq;
        logic [15:0] vaddr;
        logic        crw;
        logic [15:0] caddr;
        logic [7:0]  cwdata;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [7:0]  dwdata;
    } slot_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        burst_run     = 0;
        exp_vid_data  = 8'h00;
        exp_cpu_rdata = 8'h00;
        exp_dma_rdata = 8'h00;
    endtask

    function automatic slot_t idle_slot();
        slot_t s;
        s       = '0;
        s.crw   = 1'b1;
        return s;
    endfunction

    task automatic drive(input slot_t s);
        bus.vid_req   = s.vreq;
        bus.vid_addr  = s.vaddr;
        bus.cpu_rw    = s.crw;
        bus.cpu_addr  = s.caddr;
        bus.cpu_wdata = s.cwdata;
        bus.dma_req   = s.dreq;
        bus.dma_we    = s.dwe;
        bus.dma_addr  = s.daddr;
        bus.dma_wdata = s.dwdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".phi0"},      32'(bus.phi0),      32'h0);
        check({tag, ".vid_valid"}, 32'(bus.vid_valid), 32'h0);
        check({tag, ".vid_data"},  32'(bus.vid_data),  32'h0);
        check({tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'h0);
        check({tag, ".cpu_ce"},    32'(bus.cpu_ce),    32'h0);
        check({tag, ".dma_grant"}, 32'(bus.dma_grant), 32'h0);
        check({tag, ".dma_rdata"}, 32'(bus.dma_rdata), 32'h0);
        check({tag, ".dma_done"},  32'(bus.dma_done),  32'h0);
        check({tag, ".ram_addr"},  32'(bus.ram_addr),  32'h0);
        check({tag, ".ram_we"},    32'(bus.ram_we),    32'h0);
        check({tag, ".ram_wdata"}, 32'(bus.ram_wdata), 32'h0);
    endtask

    // One full bus cycle, entered at the negedge where cnt==0. Expectations come from
    // the arbitration rules applied to this cycle's requests and the model memory.
    task automatic run_period(input slot_t s, output logic dma_own);
        logic [15:0] acc_addr;
        logic        acc_we;
        logic [7:0]  acc_wdata;
        logic [7:0]  vid_val;
        dma_own   = s.dreq && (burst_run < DMA_BURST);
        burst_run = dma_own ? burst_run + 1 : 0;
        acc_addr  = dma_own ? s.daddr  : s.caddr;
        acc_we    = dma_own ? s.dwe    : !s.crw;
        acc_wdata = dma_own ? s.dwdata : s.cwdata;
        vid_val   = ref_mem[s.vaddr];
        drive(s);
        for (int t = 0; t < PERIOD; t++) begin
            if (t == 3 && s.vreq) exp_vid_data = vid_val;
            if (t == HALF_LEN + 3 && !acc_we) begin
                if (dma_own) exp_dma_rdata = ref_mem[acc_addr];
                else         exp_cpu_rdata = ref_mem[acc_addr];
            end
            check("phi0",      32'(bus.phi0),      32'(t >= HALF_LEN));
            check("vid_valid", 32'(bus.vid_valid), 32'(t == 3 && s.vreq));
            check("vid_data",  32'(bus.vid_data),  32'(exp_vid_data));
            check("cpu_ce",    32'(bus.cpu_ce),    32'(t == PERIOD - 1 && !dma_own));
            check("dma_done",  32'(bus.dma_done),  32'(t == PERIOD - 1 && dma_own));
            check("dma_grant", 32'(bus.dma_grant), 32'(dma_own && t > HALF_LEN));
            check("ram_we",    32'(bus.ram_we),    32'(t == HALF_LEN + 1 && acc_we));
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rdata));
            check("dma_rdata", 32'(bus.dma_rdata), 32'(exp_dma_rdata));
            if (t == HALF_LEN + 1 && acc_we) begin
                check("wr_addr",  32'(bus.ram_addr),  32'(acc_addr));
                check("wr_wdata", 32'(bus.ram_wdata), 32'(acc_wdata));
                ref_mem[acc_addr] = acc_wdata;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        slot_t      s;
        logic       own;
        logic [9:0] pattern;

        drive(idle_slot());
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // Idle traffic: CPU owns every slot, one cpu_ce per bus cycle at cnt==49.
        repeat (3) run_period(idle_slot(), own);

        // CPU write then read of 0x0400.
        s = idle_slot();
        s.crw = 1'b0; s.caddr = 16'h0400; s.cwdata = 8'hA5;
        run_period(s, own);
        s = idle_slot();
        s.caddr = 16'h0400;
        run_period(s, own);
        check("cpu_read_0400", 32'(bus.cpu_rdata), 32'h0000_00A5);

        // Video read of 0x2000 after the CPU stores 0x3C there.
        s = idle_slot();
        s.crw = 1'b0; s.caddr = 16'h2000; s.cwdata = 8'h3C;
        run_period(s, own);
        s = idle_slot();
        s.vreq = 1'b1; s.vaddr = 16'h2000;
        run_period(s, own);
        check("vid_read_2000", 32'(bus.vid_data), 32'h0000_003C);

        // Video and DMA write to the same address in one bus cycle.
        s = idle_slot();
        s.vreq = 1'b1; s.vaddr = 16'h2000;
        s.dreq = 1'b1; s.dwe = 1'b1; s.daddr = 16'h2000; s.dwdata = 8'h5A;
        run_period(s, own);
        check("vid_old_value", 32'(bus.vid_data), 32'h0000_003C);
        check("dma_won_slot",  32'(own),          32'h1);
        s = idle_slot();
        s.vreq = 1'b1; s.vaddr = 16'h2000;
        run_period(s, own);
        check("vid_new_value", 32'(bus.vid_data), 32'h0000_005A);

        // DMA steal: request held for ten bus cycles, burst limit forces a CPU slot.
        pattern = '0;
        for (int i = 0; i < 10; i++) begin
            s = idle_slot();
            s.dreq = 1'b1; s.daddr = 16'h2000 + 16'(i);
            run_period(s, own);
            pattern = {pattern[8:0], own};
        end
        check("dma_steal_pattern", 32'(pattern), 32'(10'b1111011110));

        // Random traffic in a small address window so reads hit earlier writes.
        for (int i = 0; i < 40; i++) begin
            s.vreq   = 1'($urandom_range(0, 1));
            s.vaddr  = 16'h2000 + 16'($urandom_range(0, 15));
            s.crw    = 1'($urandom_range(0, 1));
            s.caddr  = 16'h2000 + 16'($urandom_range(0, 15));
            s.cwdata = 8'($urandom);
            s.dreq   = ($urandom_range(0, 9) < 6);
            s.dwe    = 1'($urandom_range(0, 1));
            s.daddr  = 16'h2000 + 16'($urandom_range(0, 15));
            s.dwdata = 8'($urandom);
            run_period(s, own);
        end

        // Reset landing on the select clock of a CPU write.
        s = idle_slot();
        s.crw = 1'b0; s.caddr = 16'h2001; s.cwdata = 8'hEE;
        if (ref_mem[16'h2001] == 8'hEE) s.cwdata = 8'h11;
        drive(s);
        repeat (HALF_LEN) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_we_0", 32'(bus.ram_we), 32'h0);
        @(negedge clk);
        check("rst_we_1", 32'(bus.ram_we), 32'h0);
        check("rst_mem_kept", 32'(mem[16'h2001]), 32'(ref_mem[16'h2001]));
        drive(idle_slot());
        reset = 1'b0;
        model_reset();
        check_all_zero("post_reset");
        repeat (2) run_period(idle_slot(), own);
        check("post_reset_mem", 32'(mem[16'h2001]), 32'(ref_mem[16'h2001]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
